srff_bank_arbiter: RTL and testbench
====================================

// Module: srff_bank_arbiter
// PURPOSE
//  Shares one bank of NBITS SR flip-flops between NREQ requesters.
//  - Each requester issues a {s,r} command against one bit index.
//  - A round-robin arbiter grants one command at a time.
//  - A 3-state FSM sequences capture, apply and completion.
//  - Sits between control agents and the status/flag flops they set and clear.
// PARAMETERS
//  NREQ   4  number of requesters (>=2)
//  NBITS  8  number of SR flip-flops in the bank (>=2)
//  IW     $clog2(NBITS)  bit-index width (derived, not overridden)
// PORTS
//  clk         in   1         single clock, rising edge
//  rst         in   1         asynchronous, active-high reset
//  req_valid   in   NREQ      request i pending; held until req_ready[i]
//  req_sr      in   2*NREQ    {s,r} of requester i at [2i+1:2i]
//  req_idx     in   IW*NREQ   target bit of requester i at [IW*i+:IW]
//  req_ready   out  NREQ      one-hot accept pulse; command captured this edge
//  done        out  1         one-cycle completion pulse
//  done_id     out  $clog2(NREQ)  requester whose command completed
//  err         out  1         qualifies done: command rejected, bank unchanged
//  q           out  NBITS     bank state
//  q_bar       out  NBITS     always ~q
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, q=0, q_bar=all-1, rr pointer=0,
//   done=0, err=0, done_id=0, req_ready=0. No pending command survives.
//  FSM states:
//   IDLE : req_ready[w]=1 (combinational) for winner w when any req_valid.
//          At the edge, latch {sr,idx,w}; next state APPLY. Otherwise stay.
//   APPLY: update bank[idx] at the edge, then next state DONE.
//          00=hold, 01=q<=0, 10=q<=1.
//          11, or idx>=NBITS: no bank change; latch err=1.
//   DONE : done=1, done_id=w, err valid for this cycle only.
//          Pointer <= w+1 (mod NREQ); next state IDLE.
//  Arbitration: round-robin, searching from pointer upward with wrap.
//   The pointer advances only on completion.
//   A requester that deasserts valid before ready is simply skipped.
//  Latency: ready at edge k; q updated after edge k+1; done high in the
//   cycle after edge k+1. Throughput is 1 command per 3 cycles.
//  Only the addressed bit changes; all other bits hold.
//  q/q_bar are registered, and q_bar==~q in every cycle, including reset.
//  Simultaneous valids: exactly one ready per IDLE cycle; losers wait.
//  Reset during APPLY/DONE: command discarded, no done pulse, bank cleared.
//  req_ready is never asserted outside IDLE or while rst=1.
// STRUCTURE
//  Package srff_pkg:
//   - localparams SR_HOLD=2'b00, SR_RST=2'b01, SR_SET=2'b10, SR_BAD=2'b11.
//   - typedef of FSM state enum {IDLE, APPLY, DONE}.
//  Sub-module rr_arbiter #(N):
//   - inputs req[N] and ptr; outputs one-hot gnt and gnt_id.
//   - purely combinational.
//  The top holds the FSM, command latch, pointer and bank registers.
// TESTING
//  1 Reset: assert rst mid-cycle, no clk edge -> q=0x00, q_bar=0xFF,
//    done=0, req_ready=0 immediately.
//  2 Single set: req0 {s,r}=10, idx=3 -> ready[0] at edge k, q=0x08 after
//    edge k+1, done=1, done_id=0, err=0 next cycle; then req0 01 idx=3
//    -> q=0x00.
//  3 Contention: all 4 valid with set on idx 0..3 -> grant order 0,1,2,3,
//    one per 3 cycles; q=0x0F at the end. Repeat with pointer=2: order
//    2,3,0,1.
//  4 Illegal: req1 {s,r}=11 idx=5 with q=0x20 -> done, err=1, done_id=1,
//    q stays 0x20. With NBITS=6, idx=7 -> err=1.
//  5 Hold: req2 00 idx=0 -> done, err=0, q unchanged.
//  6 Reset mid-op: rst during APPLY -> no done pulse, q=0x00, pointer=0;
//    a held request is re-granted after rst falls.
//  Checker every cycle: q_bar==~q, $onehot0(req_ready), done implies the
//    previous state was APPLY.

Source files
------------

// File: rtl/srff_pkg.sv
// Shared definitions for the SR flip-flop bank arbiter.
//   SR_* : encodings of the {s,r} command field
//   state_e : sequencing FSM states (capture -> apply -> completion)
package srff_pkg;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_BAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : N request lines
//   ptr    : highest-priority index; the search runs ptr, ptr+1, ... with wrap
//   gnt    : one-hot grant (all zero when no request)
//   gnt_id : binary index of the granted request
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id
);

  logic [W:0] cand;
  logic       found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit so the wrap also works when N is not a power of two.
      cand = {1'b0, ptr} + (W+1)'(i);
      if (cand >= (W+1)'(N)) cand = cand - (W+1)'(N);
      if (!found && req[cand[W-1:0]]) begin
        found               = 1'b1;
        gnt[cand[W-1:0]]    = 1'b1;
        gnt_id              = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/srff_bank_arbiter.sv
// Bank of NBITS SR flip-flops shared by NREQ requesters through a
// round-robin arbiter; one command is captured, applied and reported at a time.
//   clk, rst   : clock and asynchronous active-high reset
//   req_valid  : per-requester pending command, held until req_ready
//   req_sr     : {s,r} of requester i at [2i+1:2i]
//   req_idx    : target bit of requester i at [IW*i +: IW]
//   req_ready  : one-hot accept, command captured at the coming edge
//   done       : one-cycle completion pulse
//   done_id    : requester whose command completed
//   err        : with done, command was rejected and the bank is unchanged
//   q, q_bar   : bank state and its complement
//
// state | meaning
// IDLE  | offering the arbiter winner a grant; capture on the edge
// APPLY | captured command updates the addressed bit at the edge
// DONE  | completion pulse, pointer moves past the served requester
module srff_bank_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int NBITS = 8,
  localparam int IW    = $clog2(NBITS),
  localparam int NW    = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [2*NREQ-1:0]  req_sr,
  input  logic [IW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]    req_ready,
  output logic               done,
  output logic [NW-1:0]      done_id,
  output logic               err,
  output logic [NBITS-1:0]   q,
  output logic [NBITS-1:0]   q_bar
);

  import srff_pkg::*;

  state_e            state_q, state_d;
  logic [1:0]        sr_q, sr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NW-1:0]     id_q, id_d;
  logic [NW-1:0]     ptr_q, ptr_d;
  logic              err_q, err_d;
  logic [NBITS-1:0]  q_q, q_d;
  logic [NBITS-1:0]  q_bar_q, q_bar_d;

  logic [NREQ-1:0]   gnt;
  logic [NW-1:0]     gnt_id;
  logic [1:0]        sel_sr;
  logic [IW-1:0]     sel_idx;
  logic              idx_ok;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    sel_sr  = '0;
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_sr  = req_sr[2*i +: 2];
        sel_idx = req_idx[IW*i +: IW];
      end
    end
  end

  // The index field can address past the bank when NBITS is not a power of two.
  assign idx_ok = (int'(idx_q) < NBITS);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    q_d     = q_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          sr_d    = sel_sr;
          idx_d   = sel_idx;
          id_d    = gnt_id;
          err_d   = 1'b0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        err_d = (sr_q == SR_BAD) || !idx_ok;
        for (int i = 0; i < NBITS; i++) begin
          if (idx_ok && (IW'(i) == idx_q)) begin
            case (sr_q)
              SR_SET:  q_d[i] = 1'b1;
              SR_RST:  q_d[i] = 1'b0;
              default: ;
            endcase
          end
        end
        state_d = DONE;
      end
      DONE: begin
        if (id_q == NW'(NREQ-1)) ptr_d = '0;
        else                     ptr_d = id_q + NW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Complement is registered alongside q so both come straight from flops.
    q_bar_d = ~q_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      q_q     <= '0;
      q_bar_q <= '1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      q_q     <= q_d;
      q_bar_q <= q_bar_d;
    end
  end

  // Reset forces IDLE asynchronously, so ready must also be masked by rst itself.
  assign req_ready = ((state_q == IDLE) && !rst) ? gnt : '0;
  assign done      = (state_q == DONE);
  assign done_id   = done ? id_q : '0;
  assign err       = done & err_q;
  assign q         = q_q;
  assign q_bar     = q_bar_q;

endmodule

// File: tb/tb_srff_bank_arbiter.sv
module tb_srff_bank_arbiter;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] CLR  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] BAD  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [7:0]  req_sr    = '0;
  logic [11:0] req_idx   = '0;
  logic [3:0]  req_ready;
  logic        done;
  logic [1:0]  done_id;
  logic        err;
  logic [7:0]  q, q_bar;

  logic [3:0]  req_valid6 = '0;
  logic [7:0]  req_sr6    = '0;
  logic [11:0] req_idx6   = '0;
  logic [3:0]  req_ready6;
  logic        done6;
  logic [1:0]  done_id6;
  logic        err6;
  logic [5:0]  q6, q_bar6;

  int errors = 0;
  int checks = 0;

  srff_bank_arbiter #(.NREQ(4), .NBITS(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sr(req_sr), .req_idx(req_idx),
    .req_ready(req_ready), .done(done), .done_id(done_id), .err(err), .q(q), .q_bar(q_bar)
  );

  srff_bank_arbiter #(.NREQ(4), .NBITS(6)) dut6 (
    .clk(clk), .rst(rst), .req_valid(req_valid6), .req_sr(req_sr6), .req_idx(req_idx6),
    .req_ready(req_ready6), .done(done6), .done_id(done_id6), .err(err6), .q(q6), .q_bar(q_bar6)
  );

  always #5 clk = ~clk;

  // Per-cycle invariants.
  logic r1 = 1'b0, r2 = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    checks++;
    if (q_bar !== ~q) begin errors++; $display("FAIL qbar_inv: q_bar=%h required %h", q_bar, ~q); end
    checks++;
    if (q_bar6 !== ~q6) begin errors++; $display("FAIL qbar6_inv: q_bar=%h required %h", q_bar6, ~q6); end
    checks++;
    if (!$onehot0(req_ready)) begin errors++; $display("FAIL ready_onehot: req_ready=%b required onehot0", req_ready); end
    if (done === 1'b1) begin
      checks++;
      if (!r2 || prev_done) begin errors++; $display("FAIL done_seq: grant2ago=%b prev_done=%b required 1/0", r2, prev_done); end
    end
    r2 = r1;
    r1 = |req_ready;
    prev_done = done;
  end

  logic        obs_timeout, obs_apply_done, obs_done, obs_err, obs_after_done;
  logic [3:0]  obs_ready;
  logic [7:0]  obs_apply_q, obs_q;
  logic [1:0]  obs_id;
  int          obs_wait;
  int          order[4];
  int          gcyc[4];
  int          cont_n;
  logic        last_done;
  logic [1:0]  last_id;
  logic        o6_timeout, o6_done, o6_err;
  logic [5:0]  o6_q;

  task automatic set_req(input int id, input logic [1:0] sr, input logic [2:0] idx);
    req_sr[2*id +: 2]  = sr;
    req_idx[3*id +: 3] = idx;
    req_valid[id]      = 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives one command and records what the DUT shows at each step.
  task automatic issue(input int id, input logic [1:0] sr, input logic [2:0] idx);
    int n;
    set_req(id, sr, idx);
    #1;
    n = 0;
    while (req_ready[id] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    obs_timeout = (n >= 20);
    obs_wait    = n;
    obs_ready   = req_ready;
    @(posedge clk); #1;
    req_valid[id]  = 1'b0;
    obs_apply_q    = q;
    obs_apply_done = done;
    @(posedge clk); #1;
    obs_q   = q;
    obs_done = done;
    obs_id  = done_id;
    obs_err = err;
    @(posedge clk); #1;
    obs_after_done = done;
  endtask

  task automatic issue6(input logic [1:0] sr, input logic [2:0] idx);
    int n;
    req_sr6[1:0]  = sr;
    req_idx6[2:0] = idx;
    req_valid6[0] = 1'b1;
    #1;
    n = 0;
    while (req_ready6[0] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    o6_timeout = (n >= 20);
    @(posedge clk); #1;
    req_valid6[0] = 1'b0;
    @(posedge clk); #1;
    o6_done = done6;
    o6_err  = err6;
    o6_q    = q6;
    @(posedge clk); #1;
  endtask

  task automatic run_contention();
    int n, cyc, id;
    n = 0; cyc = 0;
    #1;
    while (n < 4 && cyc < 60) begin
      if (req_ready != 4'b0) begin
        id = 0;
        for (int i = 0; i < 4; i++) if (req_ready[i]) id = i;
        order[n] = id;
        gcyc[n]  = cyc;
        n++;
        @(posedge clk); #1; cyc++;
        req_valid[id] = 1'b0;
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
    cont_n = n;
    @(posedge clk); #1;
    last_done = done;
    last_id   = done_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL rst_q: got %h required 00", q); end
    checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL rst_qbar: got %h required ff", q_bar); end
    checks++; if (done !== 1'b0 || err !== 1'b0 || done_id !== 2'd0) begin errors++; $display("FAIL rst_done: got %b/%b/%0d required 0/0/0", done, err, done_id); end
    issue(0, SET, 3'd7);
    checks++; if (obs_q !== 8'h80) begin errors++; $display("FAIL pre_rst_q: got %h required 80", obs_q); end
    // Asynchronous assertion between edges.
    #2;
    req_valid[1] = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL async_q: got %h required 00", q); end
    checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL async_qbar: got %h required ff", q_bar); end
    checks++; if (req_ready !== 4'b0000 || done !== 1'b0) begin errors++; $display("FAIL async_ready: got %b/%b required 0000/0", req_ready, done); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready_held: got %b required 0000", req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ready_after_rst: got %b required 0010", req_ready); end
    req_valid[1] = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL ready_withdrawn: got %b required 0000", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_set();
    issue(0, SET, 3'd3);
    checks++; if (obs_timeout !== 1'b0 || obs_wait != 0) begin errors++; $display("FAIL set_wait: got timeout=%b wait=%0d required 0/0", obs_timeout, obs_wait); end
    checks++; if (obs_ready !== 4'b0001) begin errors++; $display("FAIL set_ready: got %b required 0001", obs_ready); end
    checks++; if (obs_apply_q !== 8'h00 || obs_apply_done !== 1'b0) begin errors++; $display("FAIL set_apply: got q=%h done=%b required 00/0", obs_apply_q, obs_apply_done); end
    checks++; if (obs_q !== 8'h08) begin errors++; $display("FAIL set_q: got %h required 08", obs_q); end
    checks++; if (obs_done !== 1'b1 || obs_id !== 2'd0 || obs_err !== 1'b0) begin errors++; $display("FAIL set_done: got %b/%0d/%b required 1/0/0", obs_done, obs_id, obs_err); end
    checks++; if (obs_after_done !== 1'b0) begin errors++; $display("FAIL set_pulse: got done=%b required 0", obs_after_done); end
    issue(0, CLR, 3'd3);
    checks++; if (obs_q !== 8'h00 || obs_done !== 1'b1 || obs_err !== 1'b0) begin errors++; $display("FAIL clr: got q=%h done=%b err=%b required 00/1/0", obs_q, obs_done, obs_err); end
  endtask

  task automatic test_contention();
    pulse_reset();
    for (int i = 0; i < 4; i++) set_req(i, SET, 3'(i));
    run_contention();
    checks++; if (cont_n != 4) begin errors++; $display("FAIL cont_grants: got %0d required 4", cont_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (order[i] != i || gcyc[i] != 3*i) begin errors++; $display("FAIL cont_order%0d: got id=%0d cyc=%0d required %0d/%0d", i, order[i], gcyc[i], i, 3*i); end
    end
    checks++; if (last_done !== 1'b1 || last_id !== 2'd3) begin errors++; $display("FAIL cont_last: got %b/%0d required 1/3", last_done, last_id); end
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL cont_q: got %h required 0f", q); end
    issue(1, HOLD, 3'd0);
    checks++; if (obs_id !== 2'd1 || obs_q !== 8'h0F) begin errors++; $display("FAIL ptr_move: got id=%0d q=%h required 1/0f", obs_id, obs_q); end
    for (int i = 0; i < 4; i++) set_req(i, SET, 3'(4 + i));
    run_contention();
    checks++; if (cont_n != 4) begin errors++; $display("FAIL cont2_grants: got %0d required 4", cont_n); end
    checks++; if (order[0] != 2 || order[1] != 3 || order[2] != 0 || order[3] != 1) begin errors++; $display("FAIL cont2_order: got %0d%0d%0d%0d required 2301", order[0], order[1], order[2], order[3]); end
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL cont2_q: got %h required ff", q); end
  endtask

  task automatic test_illegal();
    pulse_reset();
    issue(0, SET, 3'd5);
    checks++; if (obs_q !== 8'h20) begin errors++; $display("FAIL ill_setup: got %h required 20", obs_q); end
    issue(1, BAD, 3'd5);
    checks++; if (obs_done !== 1'b1 || obs_err !== 1'b1 || obs_id !== 2'd1) begin errors++; $display("FAIL ill_err: got %b/%b/%0d required 1/1/1", obs_done, obs_err, obs_id); end
    checks++; if (obs_q !== 8'h20) begin errors++; $display("FAIL ill_q: got %h required 20", obs_q); end
    issue6(SET, 3'd5);
    checks++; if (o6_timeout !== 1'b0 || o6_done !== 1'b1 || o6_err !== 1'b0 || o6_q !== 6'h20) begin errors++; $display("FAIL n6_top: got t=%b d=%b e=%b q=%h required 0/1/0/20", o6_timeout, o6_done, o6_err, o6_q); end
    issue6(SET, 3'd7);
    checks++; if (o6_done !== 1'b1 || o6_err !== 1'b1 || o6_q !== 6'h20) begin errors++; $display("FAIL n6_range: got d=%b e=%b q=%h required 1/1/20", o6_done, o6_err, o6_q); end
  endtask

  task automatic test_hold();
    issue(2, HOLD, 3'd0);
    checks++; if (obs_done !== 1'b1 || obs_err !== 1'b0 || obs_id !== 2'd2) begin errors++; $display("FAIL hold_done: got %b/%b/%0d required 1/0/2", obs_done, obs_err, obs_id); end
    checks++; if (obs_q !== 8'h20) begin errors++; $display("FAIL hold_q: got %h required 20", obs_q); end
  endtask

  task automatic test_reset_mid_op();
    int n;
    set_req(3, SET, 3'd1);
    #1;
    n = 0;
    while (req_ready[3] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL mid_grant: got no ready in %0d cycles required ready[3]", n); end
    @(posedge clk); #1;
    set_req(0, SET, 3'd2);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (q !== 8'h00 || done !== 1'b0) begin errors++; $display("FAIL mid_clear: got q=%h done=%b required 00/0", q, done); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_nodone: got %b required 0", done); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr: got %b required 0001", req_ready); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || done_id !== 2'd0 || q !== 8'h04) begin errors++; $display("FAIL mid_req0: got %b/%0d/%h required 1/0/04", done, done_id, q); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_regrant: got %b required 1000", req_ready); end
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || done_id !== 2'd3 || q !== 8'h06) begin errors++; $display("FAIL mid_req3: got %b/%0d/%h required 1/3/06", done, done_id, q); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_contention();
    test_illegal();
    test_hold();
    test_reset_mid_op();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
